// File: rtl/boron_pkg.sv
// Shared constants, FSM state type and round/key-schedule functions for the BORON cipher.
package boron_pkg;

    localparam int unsigned NR    = 25;
    localparam int unsigned BLK_W = 64;
    localparam int unsigned KEY_W = 80;
    localparam int unsigned RND_W = 5;

    // Nibble n of the table is S(n); index 0 sits in the least significant nibble.
    localparam logic [63:0] SBOX = 64'h6358_F02D_AC97_1B4E;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinal
    } boron_state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        return SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [BLK_W-1:0] round_f(input logic [BLK_W-1:0] x,
                                                 input logic [BLK_W-1:0] k);
        logic [BLK_W-1:0] t;
        logic [15:0]      w0, w1, w2, w3;
        t = x ^ k;
        for (int i = 0; i < 16; i++) begin
            t[i*4 +: 4] = sbox4(t[i*4 +: 4]);
        end
        w0 = {t[14:0],  t[15]};
        w1 = {t[27:16], t[31:28]};
        w2 = {t[40:32], t[47:41]};
        w3 = {t[54:48], t[63:55]};
        w1 = w1 ^ w0;
        w3 = w3 ^ w2;
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                    input logic [RND_W-1:0] r);
        logic [KEY_W-1:0] t;
        t          = {k[66:0], k[79:67]};
        t[3:0]     = sbox4(t[3:0]);
        t[63:59]   = t[63:59] ^ r;
        return t;
    endfunction

endpackage

// File: rtl/dec_add_round_key.sv
// Combinational round-key addition: XORs a 64-bit word with the low 64 bits of an 80-bit key.
module dec_add_round_key
    import boron_pkg::*;
(
    input  logic [BLK_W-1:0] i_ark_cipher,
    input  logic [KEY_W-1:0] i_ark_key,
    output logic [BLK_W-1:0] o_ark_msg
);

    // Only the low word of the key register takes part in the addition.
    logic unused_key_hi;
    assign unused_key_hi = ^i_ark_key[KEY_W-1:BLK_W];

    assign o_ark_msg = i_ark_cipher ^ i_ark_key[BLK_W-1:0];

endmodule

// File: rtl/boron_enc.sv
// Iterative BORON encryptor, one round per clock, final key whitening before done.
// Optional BORON_KEY_OUT_EN adds a registered last_key output valid with done.
module boron_enc
    import boron_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BLK_W-1:0] plain_text,
    input  logic [KEY_W-1:0] master_key,
    output logic             done,
    output logic [BLK_W-1:0] cipher_text
`ifdef BORON_KEY_OUT_EN
    ,
    output logic [KEY_W-1:0] last_key
`endif
);

    boron_state_e     state_q, state_d;
    logic [BLK_W-1:0] reg_state, reg_state_d;
    logic [KEY_W-1:0] reg_key, reg_key_d;
    logic [RND_W-1:0] round, round_d;
    logic [BLK_W-1:0] cipher_text_d;
    logic             done_d;
    logic [BLK_W-1:0] whitened;
`ifdef BORON_KEY_OUT_EN
    logic [KEY_W-1:0] last_key_d;
`endif

    dec_add_round_key u_whiten (
        .i_ark_cipher (reg_state),
        .i_ark_key    (reg_key),
        .o_ark_msg    (whitened)
    );

    always_comb begin
        state_d       = state_q;
        reg_state_d   = reg_state;
        reg_key_d     = reg_key;
        round_d       = round;
        cipher_text_d = cipher_text;
        done_d        = 1'b0;
`ifdef BORON_KEY_OUT_EN
        last_key_d    = last_key;
`endif
        unique case (state_q)
            StIdle: begin
                // The done cycle never accepts, so back-to-back runs are 28 clocks apart.
                if (start && !done) begin
                    reg_state_d = plain_text;
                    reg_key_d   = master_key;
                    round_d     = RND_W'(1);
                    state_d     = StRun;
                end
            end
            StRun: begin
                reg_state_d = round_f(reg_state, reg_key[BLK_W-1:0]);
                reg_key_d   = key_update(reg_key, round);
                round_d     = round + RND_W'(1);
                if (round == RND_W'(NR)) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                cipher_text_d = whitened;
                done_d        = 1'b1;
`ifdef BORON_KEY_OUT_EN
                last_key_d    = reg_key;
`endif
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            reg_state   <= '0;
            reg_key     <= '0;
            round       <= '0;
            cipher_text <= '0;
            done        <= 1'b0;
`ifdef BORON_KEY_OUT_EN
            last_key    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            reg_state   <= reg_state_d;
            reg_key     <= reg_key_d;
            round       <= round_d;
            cipher_text <= cipher_text_d;
            done        <= done_d;
`ifdef BORON_KEY_OUT_EN
            last_key    <= last_key_d;
`endif
        end
    end

endmodule

// File: tb/tb_boron_enc.sv
// Self-checking bench for boron_enc: table-driven vectors against a behavioural BORON model.
module tb_boron_enc;
    import boron_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] plain_text;
    logic [79:0] master_key;
    logic        done;
    logic [63:0] cipher_text;
`ifdef BORON_KEY_OUT_EN
    logic [79:0] last_key;
`endif
    logic [79:0] probe_key;
    logic [63:0] ark_msg;

    int checks   = 0;
    int failures = 0;

    boron_enc be (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .plain_text  (plain_text),
        .master_key  (master_key),
        .done        (done),
        .cipher_text (cipher_text)
`ifdef BORON_KEY_OUT_EN
        ,
        .last_key    (last_key)
`endif
    );

    assign probe_key = be.reg_key;

    dec_add_round_key u_ark (
        .i_ark_cipher (cipher_text),
        .i_ark_key    (probe_key),
        .o_ark_msg    (ark_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_sbox(input logic [3:0] n);
        case (n)
            4'h0: return 4'hE;  4'h1: return 4'h4;  4'h2: return 4'hB;  4'h3: return 4'h1;
            4'h4: return 4'h7;  4'h5: return 4'h9;  4'h6: return 4'hC;  4'h7: return 4'hA;
            4'h8: return 4'hD;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'hF;
            4'hC: return 4'h8;  4'hD: return 4'h5;  4'hE: return 4'h3;  default: return 4'h6;
        endcase
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [63:0] m_round(input logic [63:0] x, input logic [63:0] k);
        logic [63:0] y;
        logic [15:0] w [4];
        y = x ^ k;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = m_sbox(y[4*i +: 4]);
        for (int j = 0; j < 4; j++) w[j] = y[16*j +: 16];
        w[0] = rotl16(w[0], 1);
        w[1] = rotl16(w[1], 4);
        w[2] = rotl16(w[2], 7);
        w[3] = rotl16(w[3], 9);
        w[1] = w[1] ^ w[0];
        w[3] = w[3] ^ w[2];
        return {w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [79:0] m_ks(input logic [79:0] k, input int r);
        logic [79:0] t;
        logic [4:0]  rc;
        rc       = r[4:0];
        t        = (k << 13) | (k >> 67);
        t[3:0]   = m_sbox(t[3:0]);
        t[63:59] = t[63:59] ^ rc;
        return t;
    endfunction

    function automatic void m_encrypt(input logic [63:0] pt, input logic [79:0] key,
                                      output logic [63:0] ct, output logic [63:0] pre,
                                      output logic [79:0] lk);
        logic [63:0] s;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 25; r++) begin
            s = m_round(s, k[63:0]);
            k = m_ks(k, r);
        end
        pre = s;
        ct  = s ^ k[63:0];
        lk  = k;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] ct;
        logic [63:0] pre;
        logic [79:0] lk;
    } vec_t;

    vec_t vecs [4];

    // Starts one encryption, waits (bounded) for done and checks its results.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        start      = 1'b1;
        plain_text = v.pt;
        master_key = v.key;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        plain_text = ~v.pt;
        master_key = ~v.key;
        cyc        = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 80'(cyc), 80'd27);
        chk({tag, "_cipher_text"}, {16'h0, cipher_text}, {16'h0, v.ct});
        chk({tag, "_whitening"}, {16'h0, ark_msg}, {16'h0, v.pre});
`ifdef BORON_KEY_OUT_EN
        chk({tag, "_last_key"}, last_key, v.lk);
`endif
        @(negedge clk);
        chk({tag, "_done_width"}, 80'(done), 80'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          cyc;
        int          n;
        int          ndone;
        logic [63:0] b2b_ct;
        logic [63:0] b2b_pre;
        logic [79:0] b2b_lk;
        logic [79:0] ks_key;
        logic [79:0] b2b_key;

        vecs[0].pt = 64'h0;                   vecs[0].key = 80'h0;
        vecs[1].pt = 64'hFFFF_FFFF_FFFF_FFFF; vecs[1].key = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        vecs[2].pt = 64'h0123_4567_89AB_CDEF; vecs[2].key = 80'h0;
        vecs[3].pt = 64'hFEDC_BA98_7654_3210; vecs[3].key = 80'h0123_4567_89AB_CDEF_0123;
        for (int i = 0; i < 4; i++) begin
            m_encrypt(vecs[i].pt, vecs[i].key, vecs[i].ct, vecs[i].pre, vecs[i].lk);
        end

        // Reset
        rst        = 1'b1;
        start      = 1'b0;
        plain_text = '0;
        master_key = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_done", 80'(done), 80'd0);
        chk("reset_cipher_text", {16'h0, cipher_text}, 80'h0);
        chk("reset_reg_key", probe_key, 80'h0);
`ifdef BORON_KEY_OUT_EN
        chk("reset_last_key", last_key, 80'h0);
`endif

        // Table-driven single encryptions (vector 0 covers the latency/whitening case)
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Key schedule after round 1
        ks_key = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        start      = 1'b1;
        plain_text = 64'h0;
        master_key = ks_key;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("ks_loaded", probe_key, ks_key);
        @(negedge clk);
        chk("ks_round1", probe_key, m_ks(ks_key, 1));
        cyc = 2;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("ks_latency", 80'(cyc), 80'd27);
        repeat (3) @(negedge clk);

        // Back-to-back with start held and inputs disturbed mid-run
        b2b_key = 80'h1357_9BDF_2468_ACE0_FFFF;
        m_encrypt(64'h0123_4567_89AB_CDEF, b2b_key, b2b_ct, b2b_pre, b2b_lk);
        @(negedge clk);
        start      = 1'b1;
        plain_text = 64'h0123_4567_89AB_CDEF;
        master_key = b2b_key;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                plain_text = 64'hDEAD_BEEF_DEAD_BEEF;
                master_key = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
            end
            if (cyc == 20) begin
                plain_text = 64'h0123_4567_89AB_CDEF;
                master_key = b2b_key;
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_latency", 80'(cyc), 80'd27);
        chk("b2b_ct1", {16'h0, cipher_text}, {16'h0, b2b_ct});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                plain_text = 64'h5555_AAAA_5555_AAAA;
                master_key = 80'h0F0F_0F0F_0F0F_0F0F_0F0F;
            end
        end while (done !== 1'b1 && n < 100);
        chk("b2b_period", 80'(n), 80'd28);
        chk("b2b_ct2", {16'h0, cipher_text}, {16'h0, b2b_ct});
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Abort at round 10, then a fresh encryption
        @(negedge clk);
        start      = 1'b1;
        plain_text = vecs[1].pt;
        master_key = vecs[1].key;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_round", 80'(be.round), 80'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_reg_key", probe_key, 80'h0);
        chk("abort_cipher_text", {16'h0, cipher_text}, 80'h0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 80'(ndone), 80'd0);
        run_vec(vecs[3], "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
